// File: rtl/uart_ctrl_param.sv
// uart_ctrl_param: single-clock UART with programmable 16x baud divisor, TX/RX FIFOs,
// runtime frame format, sticky error flags and RX threshold interrupt. Optional: UART_LOOPBACK_EN.
module uart_ctrl_param_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_head,
  output logic [AW:0]   o_load,
  output logic          o_full
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_load;
  logic          w_empty, w_full, w_doPush, w_doPop;

  assign w_empty  = (r_load == '0);
  assign w_full   = (r_load == (AW+1)'(DEPTH));
  // A pop frees the slot being written, so a full FIFO still accepts a simultaneous push.
  assign w_doPop  = i_pop & ~w_empty;
  assign w_doPush = i_push & (~w_full | w_doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_load <= '0;
    end else begin
      if (w_doPush) r_wp <= r_wp + 1'b1;
      if (w_doPop)  r_rp <= r_rp + 1'b1;
      r_load <= r_load + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wp] <= i_data;
  end

  assign o_head = w_empty ? 8'h00 : r_mem[r_rp];
  assign o_load = r_load;
  assign o_full = w_full;
endmodule

module uart_ctrl_param #(
  parameter int          FIFO_AW         = 4,
  parameter logic [15:0] DIV_RESET       = 16'd53,
  parameter logic [3:0]  RX_THRESH_RESET = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [3:0]  we,
  input  logic        en,
  input  logic        sel,
  output logic [7:0]  datRegOut,
  output logic [31:0] ctrlRegOut,
  output logic        interrupt,
  input  logic        uartRx,
  output logic        uartTx
);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4;
`ifdef UART_LOOPBACK_EN
  localparam logic [7:0] CFG_MASK = 8'hFE;
`else
  localparam logic [7:0] CFG_MASK = 8'hFC;
`endif

  logic [15:0] r_div, r_baudCnt;
  logic [7:0]  r_cfg;
  logic [3:0]  r_flags, r_thresh;
  logic        r_irq;
  logic        w_datWr, w_datRd, w_ctlWr, w_divWr, w_tick;
  logic [15:0] w_divNext;
  logic [3:0]  w_flagSet, w_flagClr;

  assign w_datWr   = en & ~sel & we[0];
  assign w_datRd   = en & ~sel & ~(|we);
  assign w_ctlWr   = en & sel;
  assign w_divWr   = w_ctlWr & (we[0] | we[1]);
  assign w_divNext = {(w_ctlWr & we[1]) ? din[15:8] : r_div[15:8],
                      (w_ctlWr & we[0]) ? din[7:0]  : r_div[7:0]};
  assign w_flagClr = (w_ctlWr & we[2]) ? din[23:20] : 4'h0;
  assign w_tick    = (r_baudCnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= DIV_RESET;
      r_baudCnt <= DIV_RESET;
      r_cfg     <= 8'h00;
      r_thresh  <= RX_THRESH_RESET;
      r_flags   <= 4'h0;
    end else begin
      r_div <= w_divNext;
      if (w_divWr)     r_baudCnt <= w_divNext;
      else if (w_tick) r_baudCnt <= r_div;
      else             r_baudCnt <= r_baudCnt - 16'd1;
      if (w_ctlWr & we[3]) r_cfg    <= din[31:24] & CFG_MASK;
      if (w_ctlWr & we[2]) r_thresh <= din[19:16];
      // Setting wins over a same-cycle clear so no event is lost.
      r_flags <= (r_flags & ~w_flagClr) | w_flagSet;
    end
  end

  // Transmit path
  logic [FIFO_AW:0] w_txLoad;
  logic [7:0]       w_txHead, w_txMask, r_txShift;
  logic             w_txFull, w_txEmpty, w_txPop, w_txBitEnd, w_txStopEnd, w_txSer;
  logic [2:0]       r_txState, r_txBit;
  logic [4:0]       r_txTick;
  logic             r_txParEn, r_txStop2, r_txBits7, r_txPar, r_txLine;

  uart_ctrl_param_fifo #(.AW(FIFO_AW)) u_txFifo (
    .clk(clk), .rst(rst), .i_push(w_datWr), .i_pop(w_txPop), .i_data(din[7:0]),
    .o_head(w_txHead), .o_load(w_txLoad), .o_full(w_txFull)
  );

  assign w_txEmpty   = (w_txLoad == '0);
  assign w_txMask    = r_cfg[2] ? 8'h7F : 8'hFF;
  assign w_txBitEnd  = w_tick & (r_txTick[3:0] == 4'hF);
  assign w_txStopEnd = w_tick & (r_txTick == (r_txStop2 ? 5'd31 : 5'd15));
  // Frames start on a tick so every bit spans exactly 16 ticks; STOP chains straight into START.
  assign w_txPop     = ~w_txEmpty & (((r_txState == S_IDLE) & w_tick) |
                                     ((r_txState == S_STOP) & w_txStopEnd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txState <= S_IDLE;
      r_txTick  <= 5'd0;
      r_txBit   <= 3'd0;
      r_txParEn <= 1'b0;
      r_txStop2 <= 1'b0;
      r_txBits7 <= 1'b0;
      r_txLine  <= 1'b1;
    end else begin
      r_txLine <= w_txSer;
      if (w_tick) r_txTick <= r_txTick + 5'd1;
      if (w_txPop) begin
        r_txParEn <= r_cfg[5];
        r_txStop2 <= r_cfg[3];
        r_txBits7 <= r_cfg[2];
      end
      case (r_txState)
        S_IDLE:  if (w_txPop) begin r_txState <= S_START; r_txTick <= 5'd0; end
        S_START: if (w_txBitEnd) begin r_txState <= S_DATA; r_txTick <= 5'd0; r_txBit <= 3'd0; end
        S_DATA: if (w_txBitEnd) begin
          r_txTick <= 5'd0;
          r_txBit  <= r_txBit + 3'd1;
          if (r_txBit == (r_txBits7 ? 3'd6 : 3'd7)) r_txState <= r_txParEn ? S_PAR : S_STOP;
        end
        S_PAR:   if (w_txBitEnd) begin r_txState <= S_STOP; r_txTick <= 5'd0; end
        S_STOP: if (w_txStopEnd) begin
          r_txTick  <= 5'd0;
          r_txState <= w_txPop ? S_START : S_IDLE;
        end
        default: r_txState <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_txPop) begin
      r_txShift <= w_txHead;
      r_txPar   <= (^(w_txHead & w_txMask)) ^ r_cfg[4];
    end else if ((r_txState == S_DATA) && w_txBitEnd) begin
      r_txShift <= r_txShift >> 1;
    end
  end

  always_comb begin
    w_txSer = 1'b1;
    case (r_txState)
      S_START: w_txSer = 1'b0;
      S_DATA:  w_txSer = r_txShift[0];
      S_PAR:   w_txSer = r_txPar;
      default: w_txSer = 1'b1;
    endcase
  end

  // Receive path
  logic             w_rxSrc, w_rxIn, w_rxFall, w_rxSample, w_rxPush, w_rxParBad, w_rxFull;
  logic [FIFO_AW:0] w_rxLoad;
  logic [7:0]       w_rxByte, r_rxShift;
  logic [1:0]       r_rxSync;
  logic             r_rxPrev, r_rxParEn, r_rxParOdd, r_rxBits7, r_rxParBit;
  logic [2:0]       r_rxState, r_rxBit;
  logic [3:0]       r_rxTick;

`ifdef UART_LOOPBACK_EN
  assign w_rxSrc = r_cfg[1] ? r_txLine : uartRx;
  assign uartTx  = r_cfg[1] ? 1'b1 : r_txLine;
`else
  assign w_rxSrc = uartRx;
  assign uartTx  = r_txLine;
`endif

  assign w_rxIn     = r_rxSync[1];
  assign w_rxFall   = r_rxPrev & ~w_rxIn;
  assign w_rxSample = w_tick & (r_rxTick == 4'hF);
  assign w_rxPush   = (r_rxState == S_STOP) & w_rxSample;
  assign w_rxByte   = r_rxBits7 ? {1'b0, r_rxShift[7:1]} : r_rxShift;
  assign w_rxParBad = r_rxParEn & (((^w_rxByte) ^ r_rxParOdd) != r_rxParBit);

  uart_ctrl_param_fifo #(.AW(FIFO_AW)) u_rxFifo (
    .clk(clk), .rst(rst), .i_push(w_rxPush), .i_pop(w_datRd), .i_data(w_rxByte),
    .o_head(datRegOut), .o_load(w_rxLoad), .o_full(w_rxFull)
  );

  assign w_flagSet = {w_datWr & w_txFull & ~w_txPop,
                      w_rxPush & w_rxFull & ~w_datRd,
                      w_rxPush & w_rxParBad,
                      w_rxPush & ~w_rxIn};

  // START re-aligns the tick counter to mid-bit, so later samples land on every 16th tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxSync   <= 2'b11;
      r_rxPrev   <= 1'b1;
      r_rxState  <= S_IDLE;
      r_rxTick   <= 4'd0;
      r_rxBit    <= 3'd0;
      r_rxParEn  <= 1'b0;
      r_rxParOdd <= 1'b0;
      r_rxBits7  <= 1'b0;
    end else begin
      r_rxSync <= {r_rxSync[0], w_rxSrc};
      r_rxPrev <= w_rxIn;
      if (w_tick) r_rxTick <= r_rxTick + 4'd1;
      case (r_rxState)
        S_IDLE: if (w_rxFall) begin
          r_rxState  <= S_START;
          r_rxTick   <= 4'd0;
          r_rxParEn  <= r_cfg[5];
          r_rxParOdd <= r_cfg[4];
          r_rxBits7  <= r_cfg[2];
        end
        S_START: if (w_tick && (r_rxTick == 4'd7)) begin
          r_rxTick  <= 4'd0;
          r_rxBit   <= 3'd0;
          r_rxState <= w_rxIn ? S_IDLE : S_DATA;
        end
        S_DATA: if (w_rxSample) begin
          r_rxBit <= r_rxBit + 3'd1;
          if (r_rxBit == (r_rxBits7 ? 3'd6 : 3'd7)) r_rxState <= r_rxParEn ? S_PAR : S_STOP;
        end
        S_PAR:   if (w_rxSample) r_rxState <= S_STOP;
        S_STOP:  if (w_rxSample) r_rxState <= S_IDLE;
        default: r_rxState <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_rxState == S_DATA) && w_rxSample) r_rxShift  <= {w_rxIn, r_rxShift[7:1]};
    if ((r_rxState == S_PAR) && w_rxSample)  r_rxParBit <= w_rxIn;
  end

  // Status readback and interrupt
  logic [2*FIFO_AW+3:0] w_status;
  logic                 w_irqNext;

  assign w_status  = {w_txLoad, w_rxLoad, r_txState != S_IDLE, r_rxState != S_IDLE};
  assign w_irqNext = (r_cfg[7] & (16'(w_rxLoad) >= 16'(r_thresh)) & (w_rxLoad != '0)) |
                     (r_cfg[6] & w_txEmpty & (r_txState == S_IDLE)) |
                     (|r_flags);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= w_irqNext;
  end

  assign interrupt  = r_irq;
  assign ctrlRegOut = sel ? {r_cfg, r_flags, r_thresh, r_div} : 32'(w_status);
endmodule

// File: tb/tb_uart_ctrl_param.sv
// Directed/randomised bench for uart_ctrl_param: frames are predicted from the
// UART framing rules (slot list per byte/config) and compared at mid-bit.
`timescale 1ns/1ps
module tb_uart_ctrl_param;
  localparam int AW  = 4;
  localparam int BIT = 32;  // clocks per bit with div=1

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic [3:0]  we = '0;
  logic        en = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  datRegOut;
  logic [31:0] ctrlRegOut;
  logic        interrupt;
  logic        uartRx = 1'b1;
  logic        uartTx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_ctrl_param #(.FIFO_AW(AW), .DIV_RESET(16'd53), .RX_THRESH_RESET(4'd1)) dut (
    .clk(clk), .rst(rst), .din(din), .we(we), .en(en), .sel(sel),
    .datRegOut(datRegOut), .ctrlRegOut(ctrlRegOut), .interrupt(interrupt),
    .uartRx(uartRx), .uartTx(uartTx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit s, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk); sel = s; we = w; din = d; en = 1'b1;
    @(negedge clk); en = 1'b0; we = '0; din = '0;
  endtask

  task automatic pop_rx();
    @(negedge clk); sel = 1'b0; we = '0; en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic rd_ctl(input bit s, output logic [31:0] v);
    sel = s; #1; v = ctrlRegOut;
  endtask

  // Line level for each bit slot of a frame: start, data LSB first, parity, stop(s).
  task automatic build_frame(input logic [7:0] b, input logic [7:0] cfg, input bit cp,
                             input bit cs, output int n, output logic [11:0] lv);
    int nb, ones;
    nb = cfg[2] ? 7 : 8;
    ones = 0;
    lv = '1;
    n = 0;
    lv[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin
      lv[n] = b[i]; ones += int'(b[i]); n++;
    end
    if (cfg[5]) begin lv[n] = ((ones % 2) == 1) ^ cfg[4] ^ cp; n++; end
    lv[n] = ~cs; n++;
    if (cfg[3]) begin lv[n] = 1'b1; n++; end
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] cfg, input bit cp, input bit cs);
    int n;
    logic [11:0] lv;
    build_frame(b, cfg, cp, cs, n, lv);
    for (int i = 0; i < n; i++) begin uartRx = lv[i]; idle(BIT); end
    uartRx = 1'b1;
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic [7:0] cfg, input bit waitEdge, input string tag);
    int n, t;
    logic [11:0] lv;
    build_frame(b, cfg, 1'b0, 1'b0, n, lv);
    if (waitEdge) begin
      t = 0;
      while (uartTx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
      check({tag, "_startEdge"}, 32'(uartTx), 0);
    end
    for (int i = 0; i < n; i++) begin
      idle(BIT / 2);
      check($sformatf("%s_slot%0d", tag, i), 32'(uartTx), 32'(lv[i]));
      idle(BIT / 2);
    end
  endtask

  logic [31:0] v;
  int          t, len;
  logic        lvl;
  logic [7:0]  cfg, b1, b2, eb;
  bit          cp;
  logic [7:0]  q[$];
  bit          ovr;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    check("rst_uartTx", 32'(uartTx), 1);
    check("rst_datRegOut", 32'(datRegOut), 0);
    check("rst_interrupt", 32'(interrupt), 0);
    rd_ctl(1, v); check("rst_ctrl", v, 32'h0001_0035);
    rd_ctl(0, v); check("rst_status", v, 0);

    wr(1, 4'b1011, 32'h0000_0001);
    rd_ctl(1, v); check("div_cfg_readback", v, 32'h0001_0001);

    // 0x55, 8N1: every bit is a transition, so run lengths expose bit timing
    wr(0, 4'b0001, 32'h55);
    t = 0;
    while (uartTx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    check("tx55_startEdge", 32'(uartTx), 0);
    for (int r = 0; r < 9; r++) begin
      lvl = (r % 2) == 1;
      len = 0;
      while (uartTx === lvl && len < 100) begin len++; @(negedge clk); end
      check($sformatf("tx55_run%0d", r), 32'(len), BIT);
    end
    idle(BIT / 2);
    rd_ctl(0, v); check("tx55_busyInStop", 32'(v[1]), 1);
    check("tx55_stopLevel", 32'(uartTx), 1);
    idle(24);
    rd_ctl(0, v); check("tx55_busyAfter", 32'(v[1]), 0);

    // Random frame formats, two bytes back to back (no gap between frames)
    for (int k = 0; k < 3; k++) begin
      cfg = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      wr(1, 4'b1000, {cfg, 24'h0});
      wr(0, 4'b0001, 32'(b1));
      wr(0, 4'b0001, 32'(b2));
      expect_tx(b1, cfg, 1'b1, $sformatf("txr%0d_a", k));
      expect_tx(b2, cfg, 1'b0, $sformatf("txr%0d_b", k));
      rd_ctl(0, v); check($sformatf("txr%0d_idle", k), 32'(v[11:0]), 0);
      idle(8);
    end

    // RX 0xA3 with even parity and two stop bits
    cfg = 8'h28;
    wr(1, 4'b1000, {cfg, 24'h0});
    send(8'hA3, cfg, 1'b0, 1'b0);
    idle(4);
    check("rxA3_data", 32'(datRegOut), 32'hA3);
    rd_ctl(0, v); check("rxA3_load", 32'(v[6:2]), 1);
    rd_ctl(1, v); check("rxA3_parErr", 32'(v[21]), 0);
    pop_rx();
    send(8'hA3, cfg, 1'b1, 1'b0);
    idle(4);
    check("rxA3bad_data", 32'(datRegOut), 32'hA3);
    rd_ctl(1, v); check("rxA3bad_parErr", 32'(v[21]), 1);
    wr(1, 4'b0100, 32'h0021_0000);
    rd_ctl(1, v); check("rxA3_parErrCleared", 32'(v[23:16]), 32'h01);
    pop_rx();

    // Framing error: byte still delivered, flag raises the interrupt
    cfg = 8'h00;
    wr(1, 4'b1000, {cfg, 24'h0});
    b1 = 8'($urandom);
    send(b1, cfg, 1'b0, 1'b1);
    idle(4);
    check("frm_data", 32'(datRegOut), 32'(b1));
    rd_ctl(1, v); check("frm_flag", 32'(v[20]), 1);
    check("frm_interrupt", 32'(interrupt), 1);
    wr(1, 4'b0100, 32'h0011_0000);
    idle(2);
    check("frm_irqCleared", 32'(interrupt), 0);
    pop_rx();

    // Random RX formats with occasional parity corruption
    for (int k = 0; k < 5; k++) begin
      cfg = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      b1 = 8'($urandom);
      cp = cfg[5] ? 1'($urandom_range(0, 1)) : 1'b0;
      eb = cfg[2] ? (b1 & 8'h7F) : b1;
      wr(1, 4'b1000, {cfg, 24'h0});
      send(b1, cfg, cp, 1'b0);
      idle(4);
      check($sformatf("rxr%0d_data", k), 32'(datRegOut), 32'(eb));
      rd_ctl(1, v); check($sformatf("rxr%0d_flags", k), 32'(v[23:20]), cp ? 2 : 0);
      wr(1, 4'b0100, 32'h00F1_0000);
      pop_rx();
    end

    // Overflow with threshold interrupt (rxIntEn, threshold 2)
    wr(1, 4'b1100, 32'h8002_0000);
    ovr = 1'b0;
    for (int k = 0; k < (1 << AW) + 1; k++) begin
      b1 = 8'($urandom);
      send(b1, 8'h00, 1'b0, 1'b0);
      if (q.size() < (1 << AW)) q.push_back(b1);
      else ovr = 1'b1;
      if (k < 2) begin
        idle(3);
        check($sformatf("thr_irq%0d", k), 32'(interrupt), (k == 1) ? 1 : 0);
      end
    end
    idle(4);
    rd_ctl(0, v); check("ovr_load", 32'(v[6:2]), 32'(q.size()));
    rd_ctl(1, v); check("ovr_flag", 32'(v[22]), 32'(ovr));
    for (int i = 0; i < (1 << AW); i++) begin
      b2 = q.pop_front();
      check($sformatf("ovr_read%0d", i), 32'(datRegOut), 32'(b2));
      pop_rx();
    end
    rd_ctl(0, v); check("ovr_drained", 32'(v[6:2]), 0);
    wr(1, 4'b1100, 32'h00F1_0000);

    // Start glitch of 4 ticks (8 clocks) must be rejected
    @(negedge clk); uartRx = 1'b0;
    idle(8);
    uartRx = 1'b1;
    idle(2 * BIT);
    rd_ctl(0, v); check("glitch_status", 32'(v[6:0]), 0);
    rd_ctl(1, v); check("glitch_flags", 32'(v[23:20]), 0);

    // Asynchronous reset in the middle of a start bit
    wr(0, 4'b0001, 32'hC3);
    wr(0, 4'b0001, 32'h3C);
    t = 0;
    while (uartTx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    check("rstmid_startEdge", 32'(uartTx), 0);
    idle(10);
    check("rstmid_lowBefore", 32'(uartTx), 0);
    rd_ctl(0, v); check("rstmid_txLoadBefore", 32'(v[11:7]), 1);
    #3 rst = 1'b1;
    #1 check("rstmid_uartTx", 32'(uartTx), 1);
    rd_ctl(0, v); check("rstmid_txLoad", 32'(v[11:7]), 0);
    rd_ctl(1, v); check("rstmid_div", 32'(v[15:0]), 32'd53);
    @(negedge clk); rst = 1'b0;
    idle(2);
    check("rstmid_lineIdle", 32'(uartTx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
